id_ex_hazard_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection.
- Latches decoded operands, register indices and control bits from ID. Its rs1/rs2/rd/RegWrite outputs drive the EX-stage forwarding unit and ALU-operand muxes.
- Generates the IF/ID hold and the ID/EX bubble on load-use, and honours branch flush and memory-busy freeze.

---
 rtl/id_ex_hazard_reg.sv | 164 ++++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection; optional perf counters via HAZARD_PERF_CNT_EN.
// Latency: 1 cycle ID->EX; stall_if_id is combinational from current entry and ID inputs.
// Backpressure: mem_busy freezes the entry and holds IF/ID; load-use inserts one bubble; ex_flush bubbles.
module id_ex_hazard_reg #(
    parameter int XLEN    = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               ex_flush,
    input  logic               mem_busy,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [REG_W-1:0]   ex_rs1,
    output logic [REG_W-1:0]   ex_rs2,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               stall_if_id
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_lu_stalls,
    output logic [31:0]        perf_flushes
`endif
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } entry_t;

    entry_t entry_q;
    entry_t entry_d;
    entry_t id_entry;
    logic   lu_hz;
    logic   rs1_match;
    logic   rs2_match;

    // Hazard is judged against the registered entry only, so it never depends on EX results.
    assign rs1_match = id_use_rs1 && (id_rs1 == entry_q.rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == entry_q.rd);
    assign lu_hz     = entry_q.valid && entry_q.mem_read && (entry_q.rd != '0)
                       && id_valid && (rs1_match || rs2_match);

    assign stall_if_id = mem_busy || (lu_hz && !ex_flush);

    // An invalid ID slot still loads its data, but its side-effecting bits and rd are squashed.
    always_comb begin
        id_entry            = '0;
        id_entry.valid      = id_valid;
        id_entry.pc         = id_pc;
        id_entry.rs1_data   = id_rs1_data;
        id_entry.rs2_data   = id_rs2_data;
        id_entry.imm        = id_imm;
        id_entry.rs1        = id_rs1;
        id_entry.rs2        = id_rs2;
        id_entry.rd         = id_valid ? id_rd : '0;
        id_entry.reg_write  = id_reg_write  && id_valid;
        id_entry.mem_read   = id_mem_read   && id_valid;
        id_entry.mem_write  = id_mem_write  && id_valid;
        id_entry.mem_to_reg = id_mem_to_reg && id_valid;
        id_entry.alu_src    = id_alu_src    && id_valid;
        id_entry.alu_op     = id_alu_op;
    end

    always_comb begin
        entry_d = entry_q;
        if (ex_flush) begin
            entry_d = '0;
        end else if (mem_busy) begin
            entry_d = entry_q;
        end else if (lu_hz) begin
            entry_d = '0;
        end else begin
            entry_d = id_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign ex_valid      = entry_q.valid;
    assign ex_pc         = entry_q.pc;
    assign ex_rs1_data   = entry_q.rs1_data;
    assign ex_rs2_data   = entry_q.rs2_data;
    assign ex_imm        = entry_q.imm;
    assign ex_rs1        = entry_q.rs1;
    assign ex_rs2        = entry_q.rs2;
    assign ex_rd         = entry_q.rd;
    assign ex_reg_write  = entry_q.reg_write;
    assign ex_mem_read   = entry_q.mem_read;
    assign ex_mem_write  = entry_q.mem_write;
    assign ex_mem_to_reg = entry_q.mem_to_reg;
    assign ex_alu_src    = entry_q.alu_src;
    assign ex_alu_op     = entry_q.alu_op;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q;
    logic [31:0] perf_fl_q;
    logic        lu_case;

    assign lu_case = !ex_flush && !mem_busy && lu_hz;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= '0;
            perf_fl_q <= '0;
        end else begin
            if (lu_case && (perf_lu_q != 32'hFFFF_FFFF)) begin
                perf_lu_q <= perf_lu_q + 32'd1;
            end
            if (ex_flush && (perf_fl_q != 32'hFFFF_FFFF)) begin
                perf_fl_q <= perf_fl_q + 32'd1;
            end
        end
    end

    assign perf_lu_stalls = perf_lu_q;
    assign perf_flushes   = perf_fl_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed table-driven bench for id_ex_hazard_reg plus hand-written reset and counter sequences.
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
    logic [3:0]  id_alu_op;
    logic        ex_flush, mem_busy;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic        stall_if_id;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_flushes;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .ex_flush(ex_flush), .mem_busy(mem_busy),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .stall_if_id(stall_if_id)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes)
`endif
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, mr, rw, fl, bz;
        logic [31:0] pc;
        logic        e_stall, e_valid;
        logic [4:0]  e_rd, e_rs1;
        logic        e_rw, e_mr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic u1, logic u2, logic mr, logic rw, logic fl, logic bz,
                                logic [31:0] pc, logic e_stall, logic e_valid, logic [4:0] e_rd,
                                logic [4:0] e_rs1, logic e_rw, logic e_mr, logic [31:0] e_pc);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
        t.mr = mr; t.rw = rw; t.fl = fl; t.bz = bz; t.pc = pc;
        t.e_stall = e_stall; t.e_valid = e_valid; t.e_rd = e_rd; t.e_rs1 = e_rs1;
        t.e_rw = e_rw; t.e_mr = e_mr; t.e_pc = e_pc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid     = t.v;
        id_rs1       = t.rs1;
        id_rs2       = t.rs2;
        id_rd        = t.rd;
        id_use_rs1   = t.u1;
        id_use_rs2   = t.u2;
        id_mem_read  = t.mr;
        id_mem_to_reg = t.mr;
        id_reg_write = t.rw;
        id_mem_write = 1'b0;
        id_alu_src   = 1'b1;
        id_alu_op    = 4'h3;
        ex_flush     = t.fl;
        mem_busy     = t.bz;
        id_pc        = t.pc;
        id_rs1_data  = t.pc ^ 32'hAAAA_0000;
        id_rs2_data  = t.pc ^ 32'h5555_0000;
        id_imm       = t.pc + 32'd4;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,32'h0, 0,0,0,0,0,0,32'h0));
        #12;
        chk("reset_valid", {31'b0, ex_valid}, 32'd0);
        chk("reset_rd", {27'b0, ex_rd}, 32'd0);
        chk("reset_pc", ex_pc, 32'd0);
        chk("reset_stall", {31'b0, stall_if_id}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //          v rs1 rs2 rd u1 u2 mr rw fl bz pc        | stall val rd rs1 rw mr pc
        vecs.push_back(mk(1, 2, 0, 5, 1,0, 1,1, 0,0, 32'h100, 0, 1, 5, 2, 1,1, 32'h100)); // lw x5
        vecs.push_back(mk(1, 5, 1, 6, 1,1, 0,1, 0,0, 32'h104, 1, 0, 0, 0, 0,0, 32'h0));   // add uses x5: bubble
        vecs.push_back(mk(1, 5, 1, 6, 1,1, 0,1, 0,0, 32'h104, 0, 1, 6, 5, 1,0, 32'h104)); // reloaded
        vecs.push_back(mk(1, 3, 0, 0, 1,0, 1,1, 0,0, 32'h108, 0, 1, 0, 3, 1,1, 32'h108)); // lw x0
        vecs.push_back(mk(1, 0, 0, 8, 1,0, 0,1, 0,0, 32'h10c, 0, 1, 8, 0, 1,0, 32'h10c)); // reads x0: no stall
        vecs.push_back(mk(1, 1, 0, 7, 1,0, 1,1, 0,0, 32'h110, 0, 1, 7, 1, 1,1, 32'h110)); // lw x7
        vecs.push_back(mk(1, 2, 7, 9, 1,0, 0,1, 0,0, 32'h114, 0, 1, 9, 2, 1,0, 32'h114)); // rs2=7 unused
        vecs.push_back(mk(1, 4, 0,10, 1,0, 1,1, 0,0, 32'h118, 0, 1,10, 4, 1,1, 32'h118)); // lw x10
        vecs.push_back(mk(1,10, 0,11, 1,0, 1,1, 0,0, 32'h11c, 1, 0, 0, 0, 0,0, 32'h0));   // lw x11 dep x10
        vecs.push_back(mk(1,10, 0,11, 1,0, 1,1, 0,0, 32'h11c, 0, 1,11,10, 1,1, 32'h11c));
        vecs.push_back(mk(1,10, 3,12, 1,1, 0,1, 0,0, 32'h120, 0, 1,12,10, 1,0, 32'h120)); // non-adjacent use
        vecs.push_back(mk(1, 1, 0,13, 1,0, 1,1, 0,0, 32'h124, 0, 1,13, 1, 1,1, 32'h124)); // lw x13
        vecs.push_back(mk(1,13, 0,14, 1,0, 0,1, 1,0, 32'h128, 0, 0, 0, 0, 0,0, 32'h0));   // flush beats hazard
        vecs.push_back(mk(0, 2, 0,15, 1,0, 1,1, 0,0, 32'h12c, 0, 0, 0, 2, 0,0, 32'h12c)); // invalid ID
        vecs.push_back(mk(1, 1, 0, 9, 1,0, 0,1, 0,0, 32'h130, 0, 1, 9, 1, 1,0, 32'h130)); // rd=9 entry
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 5'(k+3), 0, 5'(20+k), 1,0, 0,1, 0,1, 32'h200 + 32'(4*k),
                              1, 1, 9, 1, 1,0, 32'h130));                                   // frozen
        vecs.push_back(mk(1, 6, 0,21, 1,0, 1,1, 0,0, 32'h20c, 0, 1,21, 6, 1,1, 32'h20c)); // release
        vecs.push_back(mk(1,21, 0,22, 1,0, 0,1, 0,1, 32'h210, 1, 1,21, 6, 1,1, 32'h20c)); // busy over hazard
        vecs.push_back(mk(1,21, 0,22, 1,0, 0,1, 1,1, 32'h210, 1, 0, 0, 0, 0,0, 32'h0));   // flush over busy

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, stall_if_id}, {31'b0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_rd", i), {27'b0, ex_rd}, {27'b0, vecs[i].e_rd});
            chk($sformatf("v%0d_rs1", i), {27'b0, ex_rs1}, {27'b0, vecs[i].e_rs1});
            chk($sformatf("v%0d_rw", i), {31'b0, ex_reg_write}, {31'b0, vecs[i].e_rw});
            chk($sformatf("v%0d_mr", i), {31'b0, ex_mem_read}, {31'b0, vecs[i].e_mr});
            chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_imm", i), ex_imm,
                (vecs[i].e_pc == 32'h0) ? 32'h0 : vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d_d1", i), ex_rs1_data,
                (vecs[i].e_pc == 32'h0) ? 32'h0 : vecs[i].e_pc ^ 32'hAAAA_0000);
        end

`ifdef HAZARD_PERF_CNT_EN
        chk("perf_lu_count", perf_lu_stalls, 32'd2);
        chk("perf_fl_count", perf_flushes, 32'd2);
        @(negedge clk);
        drive(mk(1, 1, 0, 5, 1,0, 1,1, 0,0, 32'h300, 0,0,0,0,0,0,32'h0));
        @(posedge clk);
        #1;
        force dut.perf_lu_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_lu_q;
        // Dependent lw x5 <- x5 alternates stall then reload.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(mk(1, 5, 0, 5, 1,0, 1,1, 0,0, 32'h304, 0,0,0,0,0,0,32'h0));
            #1;
            chk($sformatf("sat_stall%0d", k), {31'b0, stall_if_id}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            @(posedge clk);
        end
        #1;
        chk("perf_lu_sat", perf_lu_stalls, 32'hFFFF_FFFF);
`endif

        // Asynchronous reset between edges with a live entry.
        @(negedge clk);
        drive(mk(1, 1, 0, 5, 1,0, 0,1, 0,0, 32'h400, 0,0,0,0,0,0,32'h0));
        @(posedge clk);
        #1;
        chk("pre_rst_rd", {27'b0, ex_rd}, 32'd5);
        chk("pre_rst_rw", {31'b0, ex_reg_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("async_rst_rd", {27'b0, ex_rd}, 32'd0);
        chk("async_rst_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("async_rst_pc", ex_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_hold", {31'b0, ex_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_release_load", {27'b0, ex_rd}, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
